// File: rtl/lc4_iter_divider.sv
// lc4_iter_divider: 16-bit unsigned restoring divider for LC4 DIV/MOD.
// One quotient bit per cycle through a single shared cla16 subtractor.
// Both sides use valid/ready handshakes so the pipeline can stall around it.

// cla16: 16-bit carry-lookahead adder built from four 4-bit groups.
module cla16 (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        cin_i,
    output logic [15:0] sum_o
);
    logic [15:0] g, p, c;
    logic [3:0]  gg, gp;
    logic [4:0]  gc;

    // Bit generate/propagate, group lookahead, then in-group carries and sum.
    always_comb begin
        g  = a_i & b_i;
        p  = a_i ^ b_i;
        gg = '0;
        gp = '0;
        gc = '0;
        c  = '0;
        gc[0] = cin_i;
        for (int unsigned j = 0; j < 4; j++) begin
            gp[j] = &p[j*4 +: 4];
            gg[j] = g[j*4+3]
                  | (p[j*4+3] & g[j*4+2])
                  | (p[j*4+3] & p[j*4+2] & g[j*4+1])
                  | (p[j*4+3] & p[j*4+2] & p[j*4+1] & g[j*4]);
            gc[j+1] = gg[j] | (gp[j] & gc[j]);
        end
        for (int unsigned j = 0; j < 4; j++) begin
            c[j*4] = gc[j];
            for (int unsigned k = 1; k < 4; k++) begin
                c[j*4+k] = g[j*4+k-1] | (p[j*4+k-1] & c[j*4+k-1]);
            end
        end
        sum_o = p ^ c;
    end
endmodule

module lc4_iter_divider #(
    parameter int unsigned ITERS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] quotient,
    output logic [15:0] remainder
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [15:0] q_q, q_d;
    logic [15:0] r_q, r_d;
    logic [15:0] d_q, d_d;

    logic [16:0] cand;
    logic [15:0] sub_b;
    logic [15:0] diff;
    logic        c16;
    logic        ge;

    assign cand  = {r_q, q_q[15]};
    assign sub_b = ~d_q;

    cla16 u_sub (
        .a_i  (cand[15:0]),
        .b_i  (sub_b),
        .cin_i(1'b1),
        .sum_o(diff)
    );

    // Carry-out recovered from the top-bit operands and the sum bit:
    // c15 = diff15 ^ a15 ^ b15, so c16 = a15&b15 | (a15|b15)&~diff15.
    assign c16 = (cand[15] & sub_b[15]) | ((cand[15] | sub_b[15]) & ~diff[15]);
    assign ge  = cand[16] | c16;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign quotient  = q_q;
    assign remainder = r_q;

    // Next-state and datapath update for accept, iterate and handoff.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        q_d     = q_q;
        r_d     = r_q;
        d_d     = d_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    count_d = '0;
                    r_d     = '0;
                    d_d     = divisor;
                    if (divisor == '0) begin
                        q_d     = '0;
                        state_d = DONE;
                    end else begin
                        q_d     = dividend;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                r_d     = ge ? diff : cand[15:0];
                q_d     = {q_q[14:0], ge};
                count_d = count_q + 5'd1;
                if (count_q == 5'(ITERS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            q_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            q_q     <= q_d;
            r_q     <= r_d;
            d_q     <= d_d;
        end
    end
endmodule
